// File: rtl/fifo_tx_ser_if.sv
// APB slave bundle for the TX FIFO serializer.
// Carries psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out.
interface fifo_tx_ser_if #(
  parameter int WIDTH = 8
) ();
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [3:0]       paddr;
  logic [WIDTH-1:0] pwdata;
  logic [15:0]      prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/fifo_tx_ser.sv
// APB-fed TX FIFO with gapless bit serializer.
// Ports: clk, reset, apb (slave), tx_en, data_out, bit_clk, word_done, not_empty, almost_full.
module fifo_tx_ser #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int CLK_DIV   = 25,
  parameter int MSB_FIRST = 0,
  parameter int AF_LEVEL  = DEPTH - 4
) (
  input  logic          clk,
  input  logic          reset,
  fifo_tx_ser_if.slave  apb,
  input  logic          tx_en,
  output logic          data_out,
  output logic          bit_clk,
  output logic          word_done,
  output logic          not_empty,
  output logic          almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DL    = CLK_DIV - 1;
  localparam int DH    = CLK_DIV / 2;
  localparam int BL    = WIDTH - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DL[DIV_W-1:0];
  localparam logic [DIV_W-1:0] DIV_HALF = DH[DIV_W-1:0];
  localparam logic [BIT_W-1:0] BIT_LAST = BL[BIT_W-1:0];
  localparam logic [PTR_W:0]   AF_L     = AF_LEVEL[PTR_W:0];

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sh_q;
  logic [PTR_W:0]   wr_ptr, rd_ptr, level;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q, sel;
  logic [1:0]       ctrl_bits;

  logic empty, full, busy;
  logic access, data_wr, stat_rd, ctrl_wr;
  logic push, pop, flush, clr;
  logic last_tick, udr_set;
  logic wd_q, ovf_q, udr_q;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  assign access  = apb.psel & apb.penable;
  assign data_wr = access & apb.pwrite & (apb.paddr == 4'h0);
  assign stat_rd = access & ~apb.pwrite & (apb.paddr == 4'h4);
  assign ctrl_wr = access & apb.pwrite & (apb.paddr == 4'h8);

  assign ctrl_bits = 2'(apb.pwdata);
  assign flush     = ctrl_wr & ctrl_bits[0];
  assign clr       = ctrl_wr & ctrl_bits[1];

  // full is taken from the current pointers, so a same-cycle pop
  // never makes room for a write.
  assign push = data_wr & ~full;

  assign busy = (state_q == S_SHIFT);

  assign apb.pready  = 1'b1;
  assign apb.pslverr = data_wr & full;
  assign apb.prdata  = stat_rd ?
    {8'(level), 2'b00, busy, udr_q, ovf_q, almost_full, full, empty} :
    16'h0000;

  assign last_tick = busy && (div_q == DIV_LAST) && (bit_q == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    udr_set = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (tx_en && !empty) begin
            pop     = 1'b1;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last_tick) begin
            if (tx_en && !empty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              udr_set = tx_en;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= apb.pwdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      div_q <= '0;
      bit_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      wd_q <= last_tick & ~flush;
      if (flush) begin
        div_q <= '0;
        bit_q <= '0;
      end else if (pop) begin
        sh_q  <= mem[rd_ptr[PTR_W-1:0]];
        div_q <= '0;
        bit_q <= '0;
      end else if (busy) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (clr) begin
        ovf_q <= 1'b0;
      end else if (data_wr & full) begin
        ovf_q <= 1'b1;
      end
      if (clr) begin
        udr_q <= 1'b0;
      end else if (udr_set) begin
        udr_q <= 1'b1;
      end
    end
  end

  assign sel = (MSB_FIRST != 0) ? (BIT_LAST - bit_q) : bit_q;

  assign data_out    = busy & sh_q[sel];
  assign bit_clk     = busy && (div_q >= DIV_HALF);
  assign word_done   = wd_q;
  assign not_empty   = ~empty;
  assign almost_full = (level >= AF_L);

endmodule

// File: tb/tb_fifo_tx_ser.sv
// Directed bench for fifo_tx_ser across three configurations.
// u0 defaults, u1 4-bit MSB-first div 4, u2 depth 4.
module tb_fifo_tx_ser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [3:0] paddr = 4'h0;
  logic [7:0] pwdata = 8'h00;
  logic       tx_en = 1'b0;
  int         dsel = 0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_tx_ser_if #(.WIDTH(8)) a0 ();
  fifo_tx_ser_if #(.WIDTH(4)) a1 ();
  fifo_tx_ser_if #(.WIDTH(8)) a2 ();

  logic do0, bc0, wd0, ne0, af0;
  logic do1, bc1, wd1, ne1, af1;
  logic do2, bc2, wd2, ne2, af2;

  assign a0.psel    = psel && dsel == 0;
  assign a0.penable = penable;
  assign a0.pwrite  = pwrite;
  assign a0.paddr   = paddr;
  assign a0.pwdata  = pwdata;
  assign a1.psel    = psel && dsel == 1;
  assign a1.penable = penable;
  assign a1.pwrite  = pwrite;
  assign a1.paddr   = paddr;
  assign a1.pwdata  = pwdata[3:0];
  assign a2.psel    = psel && dsel == 2;
  assign a2.penable = penable;
  assign a2.pwrite  = pwrite;
  assign a2.paddr   = paddr;
  assign a2.pwdata  = pwdata;

  fifo_tx_ser u0 (
    .clk(clk), .reset(reset), .apb(a0),
    .tx_en(tx_en && dsel == 0),
    .data_out(do0), .bit_clk(bc0), .word_done(wd0),
    .not_empty(ne0), .almost_full(af0)
  );

  fifo_tx_ser #(
    .WIDTH(4), .CLK_DIV(4), .MSB_FIRST(1)
  ) u1 (
    .clk(clk), .reset(reset), .apb(a1),
    .tx_en(tx_en && dsel == 1),
    .data_out(do1), .bit_clk(bc1), .word_done(wd1),
    .not_empty(ne1), .almost_full(af1)
  );

  fifo_tx_ser #(
    .DEPTH(4), .AF_LEVEL(0)
  ) u2 (
    .clk(clk), .reset(reset), .apb(a2),
    .tx_en(tx_en && dsel == 2),
    .data_out(do2), .bit_clk(bc2), .word_done(wd2),
    .not_empty(ne2), .almost_full(af2)
  );

  logic [15:0] prd;
  logic        serr, rdy, dout, bclk, wdone, nemp, afull;

  always_comb begin
    prd = a0.prdata; serr = a0.pslverr; rdy = a0.pready;
    dout = do0; bclk = bc0; wdone = wd0; nemp = ne0; afull = af0;
    if (dsel == 1) begin
      prd = a1.prdata; serr = a1.pslverr; rdy = a1.pready;
      dout = do1; bclk = bc1; wdone = wd1; nemp = ne1; afull = af1;
    end else if (dsel == 2) begin
      prd = a2.prdata; serr = a2.pslverr; rdy = a2.pready;
      dout = do2; bclk = bc2; wdone = wd2; nemp = ne2; afull = af2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [7:0] d,
                        output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = serr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prd;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // seq[i] is the i-th bit on the wire; c counts cycles from the pop.
  task automatic run_ser(input logic [15:0] seq, input int nbits,
                         input int wlen, input int div,
                         input logic ne_at0, input int drop_at,
                         input string tag);
    int bad_d, bad_c, bad_w;
    logic [15:0] s;
    s = seq;
    bad_d = 0; bad_c = 0; bad_w = 0;
    for (int c = 0; c < nbits * div; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_ne_at_pop"}, nemp, ne_at0);
      if (dout !== s[c / div]) bad_d++;
      if (bclk !== ((c % div) >= (div / 2))) bad_c++;
      if (wdone !== (c > 0 && (c % (wlen * div)) == 0)) bad_w++;
      if (c == drop_at) tx_en = 1'b0;
    end
    chk({tag, "_data_errs"}, bad_d, 0);
    chk({tag, "_bclk_errs"}, bad_c, 0);
    chk({tag, "_wdone_errs"}, bad_w, 0);
    @(negedge clk);
    chk({tag, "_wdone_end"}, wdone, 1'b1);
    chk({tag, "_dout_idle"}, dout, 1'b0);
    chk({tag, "_bclk_idle"}, bclk, 1'b0);
    @(negedge clk);
    chk({tag, "_wdone_1cyc"}, wdone, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic        e;
  logic [15:0] r;
  int          quiet;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_dout", dout, 1'b0);
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_wdone", wdone, 1'b0);
    chk("rst_ne", nemp, 1'b0);
    chk("rst_af", afull, 1'b0);
    chk("rst_prdata_idle", prd, 16'h0000);
    chk("rst_pready", rdy, 1'b1);
    apb_rd(4'h4, r);
    chk("rst_status", r, 16'h0001);

    // 0xA5 LSB first: 1,0,1,0,0,1,0,1 then underrun
    tx_en = 1'b1;
    apb_wr(4'h0, 8'hA5, e);
    chk("a5_err", e, 1'b0);
    chk("a5_ne_queued", nemp, 1'b1);
    run_ser(16'h00A5, 8, 8, 25, 1'b0, -1, "a5");
    apb_rd(4'h4, r);
    chk("a5_status_udr", r, 16'h0011);
    apb_rd(4'h0, r);
    chk("data_read_zero", r, 16'h0000);

    // flush + clear mid-word
    apb_wr(4'h0, 8'h3C, e);
    repeat (30) @(negedge clk);
    apb_wr(4'h0, 8'h11, e);
    apb_rd(4'h4, r);
    chk("fl_status_busy", r, 16'h0130);
    apb_wr(4'h8, 8'h03, e);
    chk("fl_ctrl_err", e, 1'b0);
    chk("fl_dout", dout, 1'b0);
    chk("fl_bclk", bclk, 1'b0);
    chk("fl_ne", nemp, 1'b0);
    apb_rd(4'h4, r);
    chk("fl_status", r, 16'h0001);
    quiet = 0;
    repeat (250) begin
      @(negedge clk);
      if (wdone !== 1'b0 || dout !== 1'b0) quiet++;
    end
    chk("fl_quiet", quiet, 0);

    // drop tx_en at bit 3 of 0x81 with two words behind it
    tx_en = 1'b0;
    apb_wr(4'h0, 8'h81, e);
    apb_wr(4'h0, 8'h55, e);
    apb_wr(4'h0, 8'h0F, e);
    tx_en = 1'b1;
    run_ser(16'h0081, 8, 8, 25, 1'b1, 80, "drop");
    repeat (5) @(negedge clk);
    chk("drop_dout_idle", dout, 1'b0);
    apb_rd(4'h4, r);
    chk("drop_status", r, 16'h0200);

    // 4-bit MSB first, 0x9 then 0x6: 1,0,0,1,0,1,1,0
    dsel = 1;
    apb_wr(4'h0, 8'h09, e);
    apb_wr(4'h0, 8'h06, e);
    tx_en = 1'b1;
    run_ser(16'h0069, 8, 4, 4, 1'b1, -1, "msb");
    tx_en = 1'b0;

    // depth 4 overflow, AF_LEVEL 0
    dsel = 2;
    for (int i = 0; i < 5; i++) begin
      apb_wr(4'h0, 8'(8'h10 + i), e);
      chk($sformatf("ovf_err%0d", i), e, (i == 4));
    end
    apb_rd(4'h4, r);
    chk("ovf_status", r, 16'h040E);
    chk("ovf_af", afull, 1'b1);
    chk("ovf_ne", nemp, 1'b1);
    apb_wr(4'h4, 8'hFF, e);
    chk("stat_wr_err", e, 1'b0);
    apb_wr(4'h8, 8'h02, e);
    apb_rd(4'h4, r);
    chk("ovf_cleared", r, 16'h0406);
    apb_wr(4'h8, 8'h01, e);
    apb_rd(4'h4, r);
    chk("d4_flushed", r, 16'h0005);

    // async reset mid-SHIFT with 3 queued
    dsel = 0;
    tx_en = 1'b0;
    apb_wr(4'h8, 8'h01, e);
    apb_wr(4'h0, 8'hFF, e);
    apb_wr(4'h0, 8'h01, e);
    apb_wr(4'h0, 8'h02, e);
    apb_wr(4'h0, 8'h03, e);
    tx_en = 1'b1;
    repeat (16) @(negedge clk);
    chk("pre_rst_dout", dout, 1'b1);
    chk("pre_rst_bclk", bclk, 1'b1);
    chk("pre_rst_ne", nemp, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_dout", dout, 1'b0);
    chk("arst_bclk", bclk, 1'b0);
    chk("arst_wdone", wdone, 1'b0);
    chk("arst_ne", nemp, 1'b0);
    chk("arst_af", afull, 1'b0);
    chk("arst_prdata", prd, 16'h0000);
    chk("arst_pslverr", serr, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apb_rd(4'h4, r);
    chk("arst_status", r, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_tx_ser.md
Name: fifo_tx_ser

Overview:
Parametrised APB-fed transmit FIFO with an integrated serializer, the next generation of the Zigbee TX buffer. Software pushes WIDTH-bit words over APB. The serializer pops them and streams bits at clk/CLK_DIV with a half-period bit clock. It adds what the previous TX FIFO lacked: configurable bit order, gapless back-to-back words, an almost-full flag, sticky overflow/underrun, flush, and a readable status register.

Parameters:
WIDTH, 8, data word width (1..16)
DEPTH, 64, FIFO words; power of 2, 2..128; PTR_W = $clog2(DEPTH)
CLK_DIV, 25, clk cycles per serial bit (>=4; 25 gives 50 MHz to 2 MHz)
MSB_FIRST, 0, 0 = bit 0 transmitted first, 1 = bit WIDTH-1 first
AF_LEVEL, DEPTH-4, almost_full asserted when level >= AF_LEVEL

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  4  APB address: 0x0 DATA (W), 0x4 STATUS (R), 0x8 CTRL (W)
pwdata  in  WIDTH  APB write data
prdata  out  16  APB read data
pready  out  1  tied 1, zero wait states
pslverr  out  1  error on rejected DATA write
tx_en  in  1  serializer enable
data_out  out  1  serial bit
bit_clk  out  1  bit clock, high in second half of each bit period
word_done  out  1  1-cycle pulse after a word's last bit period
not_empty  out  1  level != 0
almost_full  out  1  level >= AF_LEVEL

Behaviour:
- Reset (async, active-high): pointers 0, level 0, serializer IDLE, div/bit counters 0, sticky bits 0. Outputs after reset: data_out=0, bit_clk=0, word_done=0, prdata=0, pslverr=0, not_empty=0, almost_full=0.
- Pointers are PTR_W+1 bits wide. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ. level = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- APB access phase is psel & penable. prdata and pslverr are combinational during the access phase and 0 otherwise.
- DATA write when not full: the word is stored and wr_ptr increments at the clock edge.
- DATA write when full: the word is dropped, pslverr=1, and overflow is set (sticky).
- Full is evaluated before any same-cycle pop, so a write on a full FIFO is rejected even when a pop occurs in that cycle.
- Push to an empty FIFO in the same cycle the serializer checks for data: no pop that cycle; the word is popped on the next check.
- STATUS read, prdata bits:
  - [0] empty
  - [1] full
  - [2] almost_full
  - [3] overflow
  - [4] underrun
  - [5] busy (serializer in SHIFT)
  - [7:6] 0
  - [15:8] level, zero-extended
- Reads of DATA/CTRL return 0. Writes to STATUS are ignored with pslverr=0.
- CTRL write:
  - bit0 = flush: rd_ptr <= wr_ptr. The serializer aborts to IDLE with data_out=0 and bit_clk=0, and no word_done is issued.
  - bit1 = clear overflow and underrun.
  - Both bits may be set together.
- Serializer FSM states: IDLE, SHIFT.
  - IDLE: if tx_en & !empty, pop the word into the shift register, set div=0 and bit=0, go to SHIFT. data_out shows the first bit from the next cycle (1-cycle latency from pop).
  - SHIFT: div counts 0..CLK_DIV-1. bit_clk=1 for div >= CLK_DIV/2 (integer division), else 0. data_out = shift bit selected by bit index and MSB_FIRST.
  - At div==CLK_DIV-1 with bit<WIDTH-1: bit increments, div returns to 0.
  - At div==CLK_DIV-1 with bit==WIDTH-1: word_done pulses on the next cycle, then:
    - tx_en & !empty: pop the next word; the next bit period starts on the next cycle with no gap.
    - tx_en & empty: set underrun (sticky), go to IDLE.
    - !tx_en: go to IDLE.
- Deasserting tx_en mid-word does not abort. The current word completes, then the serializer goes to IDLE.
- rd_ptr increments at the pop, not at word end. level therefore excludes the word in flight.
- not_empty and almost_full are combinational from level.

Test Plan:
- Push 0xA5, tx_en=1, defaults: data_out LSB-first = 1,0,1,0,0,1,0,1, each held 25 cycles; bit_clk high on div 12..24; one word_done; not_empty falls at the pop.
- MSB_FIRST=1, WIDTH=4, CLK_DIV=4, push 0x9 and 0x6: serial 1,0,0,1,0,1,1,0 with no gap between words; two word_done pulses 16 cycles apart.
- DEPTH=4, tx_en=0, 5 DATA writes: the 5th gets pslverr=1. STATUS = full|overflow with level=4 (prdata 0x040E, almost_full set since AF_LEVEL=0). After CTRL=0x2, overflow clears.
- Push 1 word, tx_en held 1: after word_done, underrun=1 and busy=0. A push plus CTRL=0x3 mid-transmission aborts immediately: level=0, data_out=0, underrun cleared.
- Drop tx_en at bit 3: the word finishes all 8 bits, then IDLE; the following queued word is not popped.
- Assert reset mid-SHIFT with 3 words queued: all outputs 0 asynchronously, STATUS reads 0x0001 after release.
